// File: rtl/ads_seg_pkg.sv
// Shared types and constants for the ADS1115 result display path:
// FSM states, active-low 7-segment patterns (bit0=a .. bit6=g) and datapath widths.
package ads_seg_pkg;

    localparam int DATA_W     = 16;
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        SHIFT = 2'd2,
        LOAD  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Patterns are stored active-low; boards with active-high drivers get the inverse.
    function automatic logic [6:0] seg_polarity(input logic [6:0] pat, input logic active_low);
        return active_low ? pat : ~pat;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/ads_seg_display_if.sv
// Valid/ready stream carrying one 16-bit ADS1115 conversion code per transfer.
interface ads_seg_display_if;

    logic [ads_seg_pkg::DATA_W-1:0] data;
    logic                           valid;
    logic                           ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/ads_seg_display_seg7_decode.sv
// One BCD digit to a 7-segment pattern; a set blank flag or a non-decimal code turns all segments off.
module seg7_decode
    import ads_seg_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_BLANK;
            endcase
        end
    end

    assign seg = seg_polarity(pat, SEG_ACTIVE_LOW != 0);

endmodule

// File: rtl/ads_seg_display.sv
// ADS1115 code -> sign + five decimal digits on six 7-segment buses via a 16-step double-dabble.
// Optional build macro ADS_SEG_LZ_BLANK_EN blanks leading zeros on led5..led2.
//
// state | meaning
// IDLE  | in_ready high, waiting for a code
// PREP  | derive sign and magnitude, clear BCD register and step counter
// SHIFT | 16 add-3/shift steps; display registers load on the last step
// LOAD  | new pattern on the leds, disp_update high for this cycle
module ads_seg_display
    import ads_seg_pkg::*;
#(
    parameter int SIGNED_IN      = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    ads_seg_display_if.slave   in_bus,
    output logic               disp_update,
    output logic [6:0]         led1_export,
    output logic [6:0]         led2_export,
    output logic [6:0]         led3_export,
    output logic [6:0]         led4_export,
    output logic [6:0]         led5_export,
    output logic [6:0]         led6_export
);

    localparam logic [6:0] RST_DIGIT = seg_polarity(SEG_0, SEG_ACTIVE_LOW != 0);
    localparam logic [6:0] RST_BLANK = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW != 0);

    logic [1:0]                   rst_meta;
    logic                         rst_n;
    state_t                       state;
    state_t                       state_nxt;
    logic [DATA_W-1:0]            code_q;
    logic [DATA_W-1:0]            mag_q;
    logic [DATA_W-1:0]            mag_shift;
    logic [BCD_W-1:0]             bcd_q;
    logic [BCD_W-1:0]             bcd_adj;
    logic [BCD_W-1:0]             bcd_nxt;
    logic [4:0]                   cnt_q;
    logic                         neg_q;
    logic                         neg_c;
    logic                         last_shift;
    logic [BCD_DIGITS-1:0]        blank;
    logic [BCD_DIGITS-1:0][6:0]   dig_seg;
    logic [6:0]                   sign_seg;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_meta <= 2'b00;
        else                rst_meta <= {rst_meta[0], 1'b1};
    end
    assign rst_n = rst_meta[1];

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_bus.valid) state_nxt = PREP;
            PREP:    state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_bus.ready = (state == IDLE);
    assign disp_update  = (state == LOAD);
    assign last_shift   = (state == SHIFT) && (cnt_q == 5'd15);

    // 16-bit negate is exact here: -32768 wraps to 8000h, which read unsigned is 32768.
    assign neg_c = (SIGNED_IN != 0) && code_q[DATA_W-1];

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
        end
    end

    assign {bcd_nxt, mag_shift} = {bcd_adj, mag_q} << 1;

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            mag_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_bus.valid) code_q <= in_bus.data;
                PREP: begin
                    neg_q <= neg_c;
                    mag_q <= neg_c ? (~code_q + 16'd1) : code_q;
                    bcd_q <= '0;
                    cnt_q <= '0;
                end
                SHIFT: begin
                    bcd_q <= bcd_nxt;
                    mag_q <= mag_shift;
                    cnt_q <= cnt_q + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ADS_SEG_LZ_BLANK_EN
    logic lz_run;

    always_comb begin
        lz_run = 1'b1;
        blank  = '0;
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            lz_run   = lz_run && (bcd_nxt[4*i +: 4] == 4'd0);
            blank[i] = lz_run;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        seg7_decode #(
            .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
        ) u_dec (
            .digit (bcd_nxt[4*g +: 4]),
            .blank (blank[g]),
            .seg   (dig_seg[g])
        );
    end

    assign sign_seg = seg_polarity(neg_q ? SEG_MINUS : SEG_BLANK, SEG_ACTIVE_LOW != 0);

    // Loaded on the edge into LOAD so the new pattern lines up with disp_update.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            led1_export <= RST_DIGIT;
            led2_export <= RST_BLANK;
            led3_export <= RST_BLANK;
            led4_export <= RST_BLANK;
            led5_export <= RST_BLANK;
            led6_export <= RST_BLANK;
        end else if (last_shift) begin
            led1_export <= dig_seg[0];
            led2_export <= dig_seg[1];
            led3_export <= dig_seg[2];
            led4_export <= dig_seg[3];
            led5_export <= dig_seg[4];
            led6_export <= sign_seg;
        end
    end

endmodule

// File: tb/tb_ads_seg_display.sv
// Directed bench for ads_seg_display: signed, unsigned and active-high instances share one input stream.
`timescale 1ns/1ps
module tb_ads_seg_display;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data  = '0;
    logic        valid = 1'b0;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ads_seg_display_if bus_s ();
    ads_seg_display_if bus_u ();
    ads_seg_display_if bus_i ();

    assign bus_s.data = data;  assign bus_s.valid = valid;
    assign bus_u.data = data;  assign bus_u.valid = valid;
    assign bus_i.data = data;  assign bus_i.valid = valid;

    logic [6:0] s1, s2, s3, s4, s5, s6;
    logic [6:0] u1, u2, u3, u4, u5, u6;
    logic [6:0] i1, i2, i3, i4, i5, i6;
    logic       upd_s, upd_u, upd_i;
    logic [34:0] s_dig, u_dig, i_dig;

    assign s_dig = {s5, s4, s3, s2, s1};
    assign u_dig = {u5, u4, u3, u2, u1};
    assign i_dig = {i5, i4, i3, i2, i1};

    ads_seg_display #(.SIGNED_IN(1), .SEG_ACTIVE_LOW(1)) dut_s (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_bus(bus_s), .disp_update(upd_s),
        .led1_export(s1), .led2_export(s2), .led3_export(s3),
        .led4_export(s4), .led5_export(s5), .led6_export(s6));

    ads_seg_display #(.SIGNED_IN(0), .SEG_ACTIVE_LOW(1)) dut_u (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_bus(bus_u), .disp_update(upd_u),
        .led1_export(u1), .led2_export(u2), .led3_export(u3),
        .led4_export(u4), .led5_export(u5), .led6_export(u6));

    ads_seg_display #(.SIGNED_IN(1), .SEG_ACTIVE_LOW(0)) dut_i (
        .clk_clk(clk), .reset_reset_n(rst_n), .in_bus(bus_i), .disp_update(upd_i),
        .led1_export(i1), .led2_export(i2), .led3_export(i3),
        .led4_export(i4), .led5_export(i5), .led6_export(i6));

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Decimal reference for led5..led1 (active-low) from a magnitude.
    function automatic logic [34:0] exp_digits(input int v);
        logic [34:0] r;
        int          d;
        int          p;
`ifdef ADS_SEG_LZ_BLANK_EN
        bit          lz;
        lz = 1'b1;
`endif
        r = '0;
        p = 10000;
        for (int k = 4; k >= 0; k--) begin
            d = (v / p) % 10;
            p = p / 10;
`ifdef ADS_SEG_LZ_BLANK_EN
            lz = lz && (d == 0) && (k != 0);
            r[7*k +: 7] = lz ? 7'h7F : seg_of(d);
`else
            r[7*k +: 7] = seg_of(d);
`endif
        end
        return r;
    endfunction

    // Handshake one code and return the cycle (relative to the accept cycle N) where disp_update shows; 0 = never.
    task automatic convert(input logic [15:0] d, output int lat);
        int waited;
        waited = 0;
        while (!bus_s.ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        data  = d;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (upd_s) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (s_dig !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL reset_held_digits got=%h exp=%h", s_dig, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (s_dig !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL reset_digits got=%h exp=%h", s_dig, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        checks++; if (s6 !== 7'h7F) begin failures++; $display("FAIL reset_led6 got=%h exp=7f", s6); end
        checks++; if (bus_s.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus_s.ready); end
        checks++; if (upd_s !== 1'b0) begin failures++; $display("FAIL reset_update got=%b exp=0", upd_s); end
        checks++; if ({i_dig, i6} !== {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F, 7'h00}) begin failures++; $display("FAIL reset_active_high got=%h exp=%h", {i_dig, i6}, {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F, 7'h00}); end
    endtask

    task automatic test_positive();
        int lat;
        convert(16'h3039, lat);
        checks++; if (lat !== 18) begin failures++; $display("FAIL pos_latency got=%0d exp=18", lat); end
        checks++; if (s_dig !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}) begin failures++; $display("FAIL pos_digits got=%h exp=%h", s_dig, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}); end
        checks++; if (s6 !== 7'h7F) begin failures++; $display("FAIL pos_led6 got=%h exp=7f", s6); end
        checks++; if (i_dig !== {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D}) begin failures++; $display("FAIL pos_active_high got=%h exp=%h", i_dig, {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D}); end
        checks++; if (i6 !== 7'h00) begin failures++; $display("FAIL pos_active_high_led6 got=%h exp=00", i6); end
        checks++; if (bus_s.ready !== 1'b0) begin failures++; $display("FAIL pos_ready_in_load got=%b exp=0", bus_s.ready); end
        @(posedge clk); #1;
        checks++; if (upd_s !== 1'b0) begin failures++; $display("FAIL pos_update_width got=%b exp=0", upd_s); end
        checks++; if (bus_s.ready !== 1'b1) begin failures++; $display("FAIL pos_ready_return got=%b exp=1", bus_s.ready); end
    endtask

    task automatic test_boundaries();
        int lat;
        convert(16'h8000, lat);
        checks++; if (lat !== 18) begin failures++; $display("FAIL min_latency got=%0d exp=18", lat); end
        checks++; if ({s6, s_dig} !== {7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}) begin failures++; $display("FAIL min_signed got=%h exp=%h", {s6, s_dig}, {7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}); end
        checks++; if ({u6, u_dig} !== {7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}) begin failures++; $display("FAIL min_unsigned got=%h exp=%h", {u6, u_dig}, {7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}); end

        convert(16'hFFFF, lat);
`ifdef ADS_SEG_LZ_BLANK_EN
        checks++; if ({s6, s_dig} !== {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}) begin failures++; $display("FAIL neg1_signed got=%h exp=%h", {s6, s_dig}, {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}); end
`else
        checks++; if ({s6, s_dig} !== {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}) begin failures++; $display("FAIL neg1_signed got=%h exp=%h", {s6, s_dig}, {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}); end
`endif
        checks++; if ({u6, u_dig} !== {7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}) begin failures++; $display("FAIL max_unsigned got=%h exp=%h", {u6, u_dig}, {7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}); end

        convert(16'h0000, lat);
`ifdef ADS_SEG_LZ_BLANK_EN
        checks++; if ({s6, s_dig} !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL zero got=%h exp=%h", {s6, s_dig}, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); end
`else
        checks++; if ({s6, s_dig} !== {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}) begin failures++; $display("FAIL zero got=%h exp=%h", {s6, s_dig}, {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}); end
`endif

        convert(16'h7FFF, lat);
        checks++; if ({s6, s_dig} !== {7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78}) begin failures++; $display("FAIL max_signed got=%h exp=%h", {s6, s_dig}, {7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h78}); end
    endtask

    task automatic test_back_to_back();
        int          acc_n;
        int          upd_n;
        int          acc_cyc [3];
        logic [15:0] acc_val [3];
        logic        acc;
        int          mag;
        logic [6:0]  e6;
        acc_n = 0;
        upd_n = 0;
        acc_cyc = '{0, 0, 0};
        acc_val = '{16'h0, 16'h0, 16'h0};
        @(posedge clk); #1;
        valid = 1'b1;
        for (int c = 0; c < 100 && upd_n < 3; c++) begin
            data = 16'(c * 1237 + 11);
            acc  = bus_s.ready && valid;
            @(posedge clk); #1;
            if (acc) begin
                if (acc_n < 3) begin
                    acc_cyc[acc_n] = c;
                    acc_val[acc_n] = data;
                end
                acc_n++;
                if (acc_n == 3) valid = 1'b0;
            end
            if (upd_s && upd_n < 3 && upd_n < acc_n) begin
                mag = acc_val[upd_n][15] ? 65536 - int'(acc_val[upd_n]) : int'(acc_val[upd_n]);
                e6  = acc_val[upd_n][15] ? 7'h3F : 7'h7F;
                checks++; if (s_dig !== exp_digits(mag)) begin failures++; $display("FAIL b2b_digits[%0d] code=%h got=%h exp=%h", upd_n, acc_val[upd_n], s_dig, exp_digits(mag)); end
                checks++; if (s6 !== e6) begin failures++; $display("FAIL b2b_led6[%0d] got=%h exp=%h", upd_n, s6, e6); end
                upd_n++;
            end
        end
        valid = 1'b0;
        checks++; if (acc_n !== 3) begin failures++; $display("FAIL b2b_accepts got=%0d exp=3", acc_n); end
        checks++; if (upd_n !== 3) begin failures++; $display("FAIL b2b_updates got=%0d exp=3", upd_n); end
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 19) begin failures++; $display("FAIL b2b_spacing01 got=%0d exp=19", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (acc_cyc[2] - acc_cyc[1] !== 19) begin failures++; $display("FAIL b2b_spacing12 got=%0d exp=19", acc_cyc[2] - acc_cyc[1]); end
    endtask

    task automatic test_reset_abort();
        int n_upd;
        repeat (2) @(posedge clk);
        #1;
        data  = 16'd1234;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (bus_s.ready !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus_s.ready); end
        rst_n = 1'b0;
        #1;
        checks++; if ({s6, s_dig} !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL abort_immediate got=%h exp=%h", {s6, s_dig}, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        checks++; if (bus_s.ready !== 1'b1) begin failures++; $display("FAIL abort_ready_in_reset got=%b exp=1", bus_s.ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        n_upd = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (upd_s) n_upd++;
        end
        checks++; if (n_upd !== 0) begin failures++; $display("FAIL abort_no_update got=%0d exp=0", n_upd); end
        checks++; if (bus_s.ready !== 1'b1) begin failures++; $display("FAIL abort_idle got=%b exp=1", bus_s.ready); end
        checks++; if ({s6, s_dig} !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}) begin failures++; $display("FAIL abort_display_held got=%h exp=%h", {s6, s_dig}, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_boundaries();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ads_seg_display.md
Name: ads_seg_display

Overview:
- Downstream consumer of the ADS1115 conversion result read over the I2C path.
- Takes one 16-bit conversion code per valid/ready handshake and converts it to sign plus five decimal digits with an iterative shift-add-3 (double-dabble) engine.
- Drives the six 7-bit segment buses led1..led6 on the board.
- Digit and sign outputs are registered and hold between updates.

Parameters:
- SIGNED_IN, 1: 1 = input is two's-complement; 0 = input is unsigned, and the sign display is always blank.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0; 0 = outputs inverted (lit when 1).

Ports:
- clk_clk  in  1  system clock, single domain
- reset_reset_n  in  1  asynchronous active-low reset
- in_data  in  16  conversion code
- in_valid  in  1  in_data valid
- in_ready  out  1  block idle, can accept
- disp_update  out  1  one-cycle pulse when led outputs change
- led1_export  out  7  units digit
- led2_export  out  7  tens digit
- led3_export  out  7  hundreds digit
- led4_export  out  7  thousands digit
- led5_export  out  7  ten-thousands digit
- led6_export  out  7  sign position

Behaviour:
- Segment bit order is bit0=a … bit6=g.
- Active-low codes: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, minus=3Fh, blank=7Fh. With SEG_ACTIVE_LOW=0, every code is bitwise inverted.
- Reset (async assert, sync release):
  - state=IDLE, in_ready=1, disp_update=0.
  - led1=0 code; led2..led6=blank.
- FSM IDLE → PREP → SHIFT → LOAD → IDLE.
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_data and go to PREP. in_ready drops the next cycle.
  - PREP (1 cycle): neg = SIGNED_IN & in_data[15]. mag = neg ? -in_data : in_data, computed as a 17-bit zero-extended magnitude. This makes -32768 yield 32768. Clear the 20-bit BCD register and a 5-bit counter.
  - SHIFT (16 cycles): each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1. Exit when the counter reaches 15.
  - LOAD (1 cycle): register all six led outputs from the BCD nibbles and neg. Pulse disp_update=1 for this cycle. Return to IDLE.
- Latency: handshake cycle N; outputs and disp_update at cycle N+18; in_ready=1 again at N+19. Throughput is one code per 19 cycles.
- in_valid while busy is ignored (not queued). The upstream holds in_data until it sees in_ready.
- led6: minus when neg, else blank. Unsigned 65535 shows led5..led1 = 6,5,5,3,5 with led6 blank.
- Maximum BCD value is 65535, which fits in 5 digits; no overflow case exists.
- Reset mid-conversion aborts the conversion. The display returns to the reset pattern and no disp_update is produced.

Optional Feature:
- Macro: ADS_SEG_LZ_BLANK_EN.
- Defined:
  - Leading-zero digits from led5 down to led2 are blanked. led1 always shows a digit.
  - The minus sign stays on led6 (fixed position).
  - Example: -1 shows led6=minus, led5..led2=blank, led1=1.
- Undefined: all five digits are always shown, zeros included.

Decomposition:
- Package ads_seg_pkg holds:
  - the state enum (IDLE, PREP, SHIFT, LOAD);
  - the 7-bit segment constants: SEG_0..SEG_9, SEG_MINUS, SEG_BLANK, all active-low;
  - the widths DATA_W=16, BCD_DIGITS=5.
- Sub-module seg7_decode: combinational 4-bit BCD plus blank flag → 7-bit pattern, applying SEG_ACTIVE_LOW. Instantiated five times.
- The sign position uses a direct constant mux.

Test Plan:
- Reset, then release with no input → led1=40h, led2..6=7Fh, in_ready=1, disp_update=0.
- SIGNED_IN=1, in_data=3039h (12345) → at N+18: led5..led1=79h,24h,30h,19h,12h; led6=7Fh; disp_update is a single 1-cycle pulse.
- in_data=8000h → led6=3Fh, led5..led1=30h,24h,78h,02h,00h (−32768). Then in_data=FFFFh → led6=3Fh, led5..led2=40h (blank=7Fh with ADS_SEG_LZ_BLANK_EN), led1=79h.
- SIGNED_IN=0, in_data=FFFFh → led6=7Fh, led5..led1=02h,12h,12h,30h,12h (65535).
- Hold in_valid high with changing in_data across 3 conversions → exactly 3 accepts, spaced 19 cycles apart. Each display matches the value sampled at its accept cycle.
- Assert reset_reset_n=0 at SHIFT cycle 7 of a conversion of 1234 → outputs return immediately to the reset pattern. After release, no disp_update occurs and the FSM is in IDLE.
